// File: rtl/raybox_pkg.sv
// rtl/raybox_pkg.sv - shared Q-format widths, fixed-point type and FSM states for the ray stages
package raybox_pkg;

  localparam int M = 12;
  localparam int N = 12;
  localparam int W = M + N;

  typedef logic signed [W-1:0] fixed_t;

  localparam fixed_t N_SAT = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC_X = 2'd1,
    CALC_Y = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/reciprocal.sv
// rtl/reciprocal.sv - combinational 1/x in signed QM.N with saturation to the largest magnitude
module reciprocal #(
  parameter int M = 12,
  parameter int N = 12
) (
  input  logic [M+N-1:0] i_data,
  input  logic           i_abs,
  output logic [M+N-1:0] o_data,
  output logic           o_sat
);

  localparam int W  = M + N;
  localparam int DW = 2 * W;
  localparam logic [W-1:0] SAT_MAG = {1'b0, {(W-1){1'b1}}};

  logic          neg;
  logic [W-1:0]  mag;
  logic [DW-1:0] num;
  logic [DW-1:0] den;
  logic [DW-1:0] quo;
  logic [W-1:0]  mag_res;

  always_comb begin
    neg = i_data[W-1];
    mag = neg ? (~i_data + 1'b1) : i_data;
    // 1/x in QM.N is 2^(2N) / |x| when both are read as raw integers
    num = DW'(1) << (2 * N);
    den = (mag == '0) ? DW'(1) : DW'(mag);
    quo = num / den;
    // Anything at or above 2^(W-1) does not fit the signed range
    o_sat   = (mag == '0) || (|quo[DW-1:W-1]);
    mag_res = o_sat ? SAT_MAG : {1'b0, quo[W-2:0]};
    o_data  = (i_abs || !neg) ? mag_res : (~mag_res + 1'b1);
  end

endmodule

// File: rtl/ray_delta_dist.sv
// rtl/ray_delta_dist.sv - DDA step lengths |1/rayDirX|, |1/rayDirY| and step signs, one shared reciprocal
module ray_delta_dist
  import raybox_pkg::*;
#(
  parameter int M = raybox_pkg::M,
  parameter int N = raybox_pkg::N
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_valid,
  output logic           i_ready,
  input  logic [M+N-1:0] i_rx,
  input  logic [M+N-1:0] i_ry,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [M+N-1:0] o_dx,
  output logic [M+N-1:0] o_dy,
  output logic           o_sat_x,
  output logic           o_sat_y,
  output logic           o_step_x,
  output logic           o_step_y
);

  localparam int LW = M + N;
  localparam logic [LW-1:0] SAT_MAG  = {1'b0, {(LW-1){1'b1}}};
  localparam logic [LW-1:0] MOST_NEG = {1'b1, {(LW-1){1'b0}}};

  state_t state_q, state_d;
  logic [LW-1:0] rx_q, rx_d, ry_q, ry_d;
  logic [LW-1:0] dx_q, dx_d, dy_q, dy_d;
  logic sat_x_q, sat_x_d, sat_y_q, sat_y_d;
  logic step_x_q, step_x_d, step_y_q, step_y_d;

  logic [LW-1:0] opnd;
  logic [LW-1:0] opnd_clamped;
  logic          opnd_zero;
  logic [LW-1:0] recip_data;
  logic          recip_sat;
  logic [LW-1:0] res_data;
  logic          res_sat;
  logic          res_step;

  // The most-negative code has no positive twin, so nudge it by one LSB
  always_comb begin
    opnd         = (state_q == CALC_Y) ? ry_q : rx_q;
    opnd_zero    = (opnd == '0);
    opnd_clamped = (opnd == MOST_NEG) ? (MOST_NEG + 1'b1) : opnd;
    res_data     = opnd_zero ? SAT_MAG : recip_data;
    res_sat      = opnd_zero | recip_sat;
    res_step     = opnd[LW-1];
  end

  reciprocal #(
    .M (M),
    .N (N)
  ) u_reciprocal (
    .i_data (opnd_clamped),
    .i_abs  (1'b1),
    .o_data (recip_data),
    .o_sat  (recip_sat)
  );

  always_comb begin
    state_d  = state_q;
    rx_d     = rx_q;
    ry_d     = ry_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    sat_x_d  = sat_x_q;
    sat_y_d  = sat_y_q;
    step_x_d = step_x_q;
    step_y_d = step_y_q;
    i_ready  = (state_q == IDLE);
    o_valid  = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          rx_d    = i_rx;
          ry_d    = i_ry;
          state_d = CALC_X;
        end
      end
      CALC_X: begin
        dx_d     = res_data;
        sat_x_d  = res_sat;
        step_x_d = res_step;
        state_d  = CALC_Y;
      end
      CALC_Y: begin
        dy_d     = res_data;
        sat_y_d  = res_sat;
        step_y_d = res_step;
        state_d  = DONE;
      end
      DONE: begin
        if (o_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rx_q     <= '0;
      ry_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      sat_x_q  <= 1'b0;
      sat_y_q  <= 1'b0;
      step_x_q <= 1'b0;
      step_y_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      sat_x_q  <= sat_x_d;
      sat_y_q  <= sat_y_d;
      step_x_q <= step_x_d;
      step_y_q <= step_y_d;
    end
  end

  assign o_dx     = dx_q;
  assign o_dy     = dy_q;
  assign o_sat_x  = sat_x_q;
  assign o_sat_y  = sat_y_q;
  assign o_step_x = step_x_q;
  assign o_step_y = step_y_q;

endmodule

// File: tb/tb_ray_delta_dist.sv
// tb/tb_ray_delta_dist.sv - directed self-checking bench for ray_delta_dist
module tb_ray_delta_dist;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic        i_ready;
  logic [23:0] i_rx;
  logic [23:0] i_ry;
  logic        o_valid;
  logic        o_ready;
  logic [23:0] o_dx;
  logic [23:0] o_dy;
  logic        o_sat_x;
  logic        o_sat_y;
  logic        o_step_x;
  logic        o_step_y;

  int checks = 0;
  int errors = 0;

  ray_delta_dist dut (
    .clk      (clk),
    .reset    (reset),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .i_rx     (i_rx),
    .i_ry     (i_ry),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_dx     (o_dx),
    .o_dy     (o_dy),
    .o_sat_x  (o_sat_x),
    .o_sat_y  (o_sat_y),
    .o_step_x (o_step_x),
    .o_step_y (o_step_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Tolerance of +/-0.2 percent around the ideal reciprocal
  task automatic chk_near(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    longint o;
    longint e;
    logic   ok;
    o  = longint'(obs);
    e  = longint'(exp);
    ok = (^obs !== 1'bx) && (o * 1000 >= e * 998) && (o * 1000 <= e * 1002);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%h expected~%h", tag, obs, exp);
    end
  endtask

  // Accept one ray at the next edge and walk it to DONE, checking the 2-edge latency
  task automatic start_ray(input logic [23:0] rx, input logic [23:0] ry);
    @(negedge clk);
    chk("ready_before_accept", {23'd0, i_ready}, 24'd1);
    i_valid = 1'b1;
    i_rx    = rx;
    i_ry    = ry;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    i_rx    = 24'h5A5A5A;
    i_ry    = 24'hA5A5A5;
    chk("valid_after_e0", {23'd0, o_valid}, 24'd0);
    chk("ready_in_calc", {23'd0, i_ready}, 24'd0);
    @(posedge clk);
    @(negedge clk);
    chk("valid_after_e1", {23'd0, o_valid}, 24'd0);
    @(posedge clk);
    @(negedge clk);
    chk("valid_after_e2", {23'd0, o_valid}, 24'd1);
  endtask

  task automatic release_ray();
    o_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o_ready = 1'b0;
    chk("valid_after_release", {23'd0, o_valid}, 24'd0);
    chk("ready_after_release", {23'd0, i_ready}, 24'd1);
  endtask

  initial begin
    reset   = 1'b1;
    i_valid = 1'b0;
    i_rx    = '0;
    i_ry    = '0;
    o_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_i_ready", {23'd0, i_ready}, 24'd1);
    chk("rst_o_valid", {23'd0, o_valid}, 24'd0);
    chk("rst_o_dx", o_dx, 24'h000000);
    chk("rst_o_dy", o_dy, 24'h000000);
    chk("rst_flags", {20'd0, o_sat_x, o_sat_y, o_step_x, o_step_y}, 24'd0);
    reset = 1'b0;

    // 1.0 and 2.0
    start_ray(24'h001000, 24'h002000);
    chk_near("t1_dx", o_dx, 24'h001000);
    chk_near("t1_dy", o_dy, 24'h000800);
    chk("t1_flags", {20'd0, o_sat_x, o_sat_y, o_step_x, o_step_y}, 24'd0);

    // Hold DONE under backpressure while the upstream side misbehaves
    for (int i = 0; i < 5; i++) begin
      i_valid = ~i_valid;
      i_rx    = 24'($urandom);
      i_ry    = 24'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("bp_o_valid", {23'd0, o_valid}, 24'd1);
      chk("bp_i_ready", {23'd0, i_ready}, 24'd0);
      chk("bp_o_dx", o_dx, 24'h001000);
      chk("bp_o_dy", o_dy, 24'h000800);
    end
    i_valid = 1'b0;
    release_ray();

    // -0.25 and -1.0
    start_ray(24'hFFFC00, 24'hFFF000);
    chk_near("t2_dx", o_dx, 24'h004000);
    chk_near("t2_dy", o_dy, 24'h001000);
    chk("t2_steps", {22'd0, o_step_x, o_step_y}, 24'd3);
    chk("t2_sats", {22'd0, o_sat_x, o_sat_y}, 24'd0);
    release_ray();

    // Zero and one LSB both saturate
    start_ray(24'h000000, 24'h000001);
    chk("t3_dx", o_dx, 24'h7FFFFF);
    chk("t3_dy", o_dy, 24'h7FFFFF);
    chk("t3_sats", {22'd0, o_sat_x, o_sat_y}, 24'd3);
    chk("t3_steps", {22'd0, o_step_x, o_step_y}, 24'd0);
    release_ray();

    // Most-negative operand and 0.5
    start_ray(24'h800000, 24'h000800);
    chk_near("t4_dx", o_dx, 24'h000002);
    chk_near("t4_dy", o_dy, 24'h002000);
    chk("t4_steps", {22'd0, o_step_x, o_step_y}, 24'd2);
    chk("t4_sats", {22'd0, o_sat_x, o_sat_y}, 24'd0);
    release_ray();

    // Reset while the second axis is being computed
    @(negedge clk);
    i_valid = 1'b1;
    i_rx    = 24'h001000;
    i_ry    = 24'h001000;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_o_valid", {23'd0, o_valid}, 24'd0);
    chk("mid_rst_i_ready", {23'd0, i_ready}, 24'd1);
    chk("mid_rst_o_dx", o_dx, 24'h000000);
    chk("mid_rst_o_dy", o_dy, 24'h000000);
    chk("mid_rst_flags", {20'd0, o_sat_x, o_sat_y, o_step_x, o_step_y}, 24'd0);

    // 0.5 and -0.25 after the reset
    start_ray(24'h000800, 24'hFFFC00);
    chk_near("t5_dx", o_dx, 24'h002000);
    chk_near("t5_dy", o_dy, 24'h004000);
    chk("t5_flags", {20'd0, o_sat_x, o_sat_y, o_step_x, o_step_y}, 24'd1);
    release_ray();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
